// File: rtl/assoc_cache_controller.sv
// assoc_cache_controller
// 2-way set-associative, read-allocate, write-through cache placed between
// the MEM stage and the SRAM controller. Each line holds two 32-bit words.
// Each set has one LRU bit, and the cache keeps saturating read hit/miss
// counters.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | accept requests, answer read hits, flush when no request
// S_FILL  | SRAM line read in flight, waiting for sram_ready
// S_ALLOC | install captured line in victim way, return selected word
// S_WRITE | SRAM write-through in flight, waiting for sram_ready
module assoc_cache_controller #(
  parameter int          SET_BITS    = 6,
  parameter int          TAG_W       = 10,
  parameter logic [31:0] ADDR_BASE   = 32'd1024,
  parameter bit          WRITE_ALLOC = 1'b0,
  parameter int          CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      address,
  input  logic [31:0]      writeData,
  input  logic             MEM_R_EN,
  input  logic             MEM_W_EN,
  input  logic             flush,
  output logic [31:0]      rdata,
  output logic             ready,
  output logic [31:0]      sram_address,
  output logic [31:0]      sram_write_data,
  output logic             sram_write_en,
  output logic             sram_read_en,
  input  logic [63:0]      sram_read_data,
  input  logic             sram_ready,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int NSETS = 1 << SET_BITS;
  localparam int AW    = TAG_W + SET_BITS + 3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_ALLOC = 2'd2;
  localparam logic [1:0] S_WRITE = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       r_state;
  logic [63:0]      r_line;
  logic             r_wa;
  logic [CNT_W-1:0] r_hit_cnt;
  logic [CNT_W-1:0] r_miss_cnt;

  logic             r_valid [2][NSETS];
  logic [TAG_W-1:0] r_tag   [2][NSETS];
  logic [63:0]      r_data  [2][NSETS];
  logic             r_lru   [NSETS];

  logic [31:0]         w_addr_off;
  logic                w_word_sel;
  logic [SET_BITS-1:0] w_index;
  logic [TAG_W-1:0]    w_tag;
  logic                w_hit0;
  logic                w_hit1;
  logic                w_hit;
  logic                w_hit_way;
  logic                w_victim;
  logic [31:0]         w_hit_word;
  logic [31:0]         w_line_word;
  logic [63:0]         w_fill_line;

  logic [1:0]  w_next_state;
  logic        w_ready;
  logic [31:0] w_rdata;
  logic        w_sram_rd;
  logic        w_sram_wr;
  logic        w_hit_event;
  logic        w_miss_event;
  logic        w_flush_now;
  logic        w_wr_hit_upd;
  logic        w_start_wa;
  logic        w_alloc;

  // The base offset only affects the cache lookup. SRAM always sees the raw address.
  assign w_addr_off = address - ADDR_BASE;
  assign w_word_sel = w_addr_off[2];
  assign w_index    = w_addr_off[SET_BITS+2:3];
  assign w_tag      = w_addr_off[AW-1:SET_BITS+3];

  generate
    if (AW < 32) begin : g_unused_hi
      logic w_unused_hi;
      assign w_unused_hi = ^w_addr_off[31:AW];
    end
  endgenerate

  logic w_unused_lo;
  assign w_unused_lo = ^w_addr_off[1:0];

  assign w_hit0    = r_valid[0][w_index] && (r_tag[0][w_index] == w_tag);
  assign w_hit1    = r_valid[1][w_index] && (r_tag[1][w_index] == w_tag);
  assign w_hit     = w_hit0 | w_hit1;
  assign w_hit_way = ~w_hit0;

  // Prefer an empty way (way0 first). Evict the LRU way only when both ways are valid.
  assign w_victim = !r_valid[0][w_index] ? 1'b0 :
                    !r_valid[1][w_index] ? 1'b1 : r_lru[w_index];

  assign w_hit_word  = w_word_sel ? r_data[w_hit_way][w_index][63:32]
                                  : r_data[w_hit_way][w_index][31:0];
  assign w_line_word = w_word_sel ? r_line[63:32] : r_line[31:0];
  assign w_alloc     = (r_state == S_ALLOC);

  // On a write-allocate refill, merge the store into the fetched line.
  always_comb begin
    w_fill_line = sram_read_data;
    if (r_wa) begin
      if (w_word_sel) w_fill_line[63:32] = writeData;
      else            w_fill_line[31:0]  = writeData;
    end
  end

  // Next-state, handshake and strobe decode.
  always_comb begin
    w_next_state = r_state;
    w_ready      = 1'b1;
    w_rdata      = 32'd0;
    w_sram_rd    = 1'b0;
    w_sram_wr    = 1'b0;
    w_hit_event  = 1'b0;
    w_miss_event = 1'b0;
    w_flush_now  = 1'b0;
    w_wr_hit_upd = 1'b0;
    w_start_wa   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (MEM_W_EN) begin
          w_ready      = 1'b0;
          w_next_state = S_WRITE;
        end else if (MEM_R_EN) begin
          if (w_hit) begin
            w_rdata     = w_hit_word;
            w_hit_event = 1'b1;
          end else begin
            w_ready      = 1'b0;
            w_miss_event = 1'b1;
            w_next_state = S_FILL;
          end
        end else if (flush) begin
          w_flush_now = 1'b1;
        end
      end
      S_FILL: begin
        w_sram_rd = 1'b1;
        w_ready   = 1'b0;
        if (sram_ready) w_next_state = S_ALLOC;
      end
      S_ALLOC: begin
        w_rdata      = w_line_word;
        w_next_state = S_IDLE;
      end
      S_WRITE: begin
        w_sram_wr = 1'b1;
        w_ready   = 1'b0;
        if (sram_ready) begin
          if (w_hit) begin
            w_wr_hit_upd = 1'b1;
            w_ready      = 1'b1;
            w_next_state = S_IDLE;
          end else if (WRITE_ALLOC) begin
            w_start_wa   = 1'b1;
            w_next_state = S_FILL;
          end else begin
            w_ready      = 1'b1;
            w_next_state = S_IDLE;
          end
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register, captured fill line and write-allocate marker.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_wa    <= 1'b0;
      r_line  <= 64'd0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_FILL && sram_ready) r_line <= w_fill_line;
      if (w_start_wa)   r_wa <= 1'b1;
      else if (w_alloc) r_wa <= 1'b0;
    end
  end

  // Valid and LRU bookkeeping. Flush clears the valid bits but leaves LRU alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NSETS; s++) begin
        r_valid[0][s] <= 1'b0;
        r_valid[1][s] <= 1'b0;
        r_lru[s]      <= 1'b0;
      end
    end else if (w_flush_now) begin
      for (int s = 0; s < NSETS; s++) begin
        r_valid[0][s] <= 1'b0;
        r_valid[1][s] <= 1'b0;
      end
    end else if (w_alloc) begin
      r_valid[w_victim][w_index] <= 1'b1;
      r_lru[w_index]             <= ~w_victim;
    end else if (w_hit_event || w_wr_hit_upd) begin
      r_lru[w_index] <= ~w_hit_way;
    end
  end

  // Tag and data storage. Contents are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_tag[w_victim][w_index]  <= w_tag;
      r_data[w_victim][w_index] <= r_line;
    end else if (w_wr_hit_upd) begin
      if (w_word_sel) r_data[w_hit_way][w_index][63:32] <= writeData;
      else            r_data[w_hit_way][w_index][31:0]  <= writeData;
    end
  end

  // Saturating read hit/miss counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_hit_event && r_hit_cnt != CNT_MAX)   r_hit_cnt  <= r_hit_cnt + CNT_ONE;
      if (w_miss_event && r_miss_cnt != CNT_MAX) r_miss_cnt <= r_miss_cnt + CNT_ONE;
    end
  end

  assign ready           = w_ready;
  assign rdata           = w_rdata;
  assign sram_read_en    = w_sram_rd;
  assign sram_write_en   = w_sram_wr;
  assign sram_address    = address;
  assign sram_write_data = writeData;
  assign hit_cnt         = r_hit_cnt;
  assign miss_cnt        = r_miss_cnt;

endmodule

// File: tb/tb_assoc_cache_controller.sv
`timescale 1ns/1ps
// Two lanes: lane 0 is write-no-allocate with 16-bit counters, and lane 1 is
// write-allocate with 3-bit counters. Lanes are exercised one after another.
module tb_assoc_cache_controller;
  localparam int          NSETS = 64;
  localparam logic [31:0] BASE  = 32'd1024;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    bit          hit;
    bit          fill;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst     = 1'b1;
  logic [31:0] address = '0;
  logic [31:0] wdata   = '0;
  logic        flush   = 1'b0;
  logic        rd [2];
  logic        wr [2];
  logic [31:0] rdata [2];
  logic        ready [2];
  logic [31:0] s_addr [2];
  logic [31:0] s_wdata [2];
  logic        s_we [2];
  logic        s_re [2];
  logic [15:0] hcnt [2];
  logic [15:0] mcnt [2];

  int checks = 0;
  int errors = 0;
  int force_dly = -1;
  exp_t sb [$];

  // Reference model: per-set tag list in recency order (front = MRU), plus
  // the architectural memory contents.
  int unsigned mset [NSETS][$];
  logic [31:0] ref_mem [logic [31:0]];
  int mhit = 0;
  int mmiss = 0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h400) return 32'h11;
    if (a == 32'h404) return 32'h22;
    return {a[15:0], ~a[15:0]} ^ 32'h3C5A_0000;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] k;
    k = {a[31:2], 2'b00};
    if (ref_mem.exists(k)) return ref_mem[k];
    return init_word(k);
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic bit in_set(input int unsigned s, input int unsigned t);
    foreach (mset[s][i]) if (mset[s][i] == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void touch(input int unsigned s, input int unsigned t);
    for (int i = 0; i < mset[s].size(); i++) begin
      if (mset[s][i] == t) begin
        mset[s].delete(i);
        break;
      end
    end
    mset[s].push_front(t);
    if (mset[s].size() > 2) void'(mset[s].pop_back());
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < NSETS; s++) mset[s].delete();
  endfunction

  function automatic logic [15:0] sat(input int v, input int ln);
    int mx;
    mx = (ln == 0) ? 65535 : 7;
    return (v > mx) ? 16'(mx) : 16'(v);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam int CW = (g == 0) ? 16 : 3;
    logic          s_rdy = 1'b0;
    logic [63:0]   s_rdata = '0;
    logic [CW-1:0] hc;
    logic [CW-1:0] mc;
    logic [63:0]   sram_mem [logic [28:0]];
    int            dly = -1;
    int            cyc = 0;
    bit            saw_fill = 1'b0;
    exp_t          e;

    assoc_cache_controller #(
      .SET_BITS(6), .TAG_W(10), .ADDR_BASE(32'd1024),
      .WRITE_ALLOC(g == 1), .CNT_W(CW)
    ) u_dut (
      .clk(clk), .rst(rst), .address(address), .writeData(wdata),
      .MEM_R_EN(rd[g]), .MEM_W_EN(wr[g]), .flush(flush),
      .rdata(rdata[g]), .ready(ready[g]),
      .sram_address(s_addr[g]), .sram_write_data(s_wdata[g]),
      .sram_write_en(s_we[g]), .sram_read_en(s_re[g]),
      .sram_read_data(s_rdata), .sram_ready(s_rdy),
      .hit_cnt(hc), .miss_cnt(mc)
    );

    assign hcnt[g] = 16'(hc);
    assign mcnt[g] = 16'(mc);

    function automatic logic [63:0] get_line(input logic [28:0] k);
      if (sram_mem.exists(k)) return sram_mem[k];
      return {init_word({k, 3'b100}), init_word({k, 3'b000})};
    endfunction

    // SRAM model: answers a strobe after a random or forced delay with a single-cycle pulse.
    always @(posedge clk) begin
      logic [63:0] ln;
      #2;
      if (s_rdy) s_rdy = 1'b0;
      else if (s_re[g] || s_we[g]) begin
        if (dly < 0) dly = (force_dly >= 0) ? force_dly : int'($urandom_range(0, 3));
        if (dly == 0) begin
          dly = -1;
          if (s_we[g]) begin
            ln = get_line(s_addr[g][31:3]);
            if (s_addr[g][2]) ln[63:32] = s_wdata[g];
            else              ln[31:0]  = s_wdata[g];
            sram_mem[s_addr[g][31:3]] = ln;
          end else begin
            s_rdata = get_line(s_addr[g][31:3]);
          end
          s_rdy = 1'b1;
        end else dly--;
      end else dly = -1;
    end

    // Monitor: pops the scoreboard whenever a pending request is acknowledged.
    always @(negedge clk) begin
      if (rd[g] || wr[g]) begin
        if (s_re[g]) saw_fill = 1'b1;
        if (s_we[g] && s_rdy && sb.size() > 0) begin
          chk("sram_address", s_addr[g], sb[0].addr);
          chk("sram_write_data", s_wdata[g], sb[0].data);
        end
        if (ready[g]) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ready: lane %0d acknowledged with empty scoreboard", g);
          end else begin
            e = sb.pop_front();
            if (!e.wr) begin
              chk("rdata", rdata[g], e.data);
              chk("hit_same_cycle", 32'(cyc == 0), 32'(e.hit));
            end
            chk("sram_fill_seen", 32'(saw_fill), 32'(e.fill));
          end
          cyc = 0;
          saw_fill = 1'b0;
        end else cyc++;
      end else begin
        cyc = 0;
        saw_fill = 1'b0;
      end
    end
  end

  task automatic finish_now();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  task automatic do_req(input int ln, input bit is_wr, input logic [31:0] addr,
                        input logic [31:0] data, input bit fl);
    exp_t e;
    int unsigned off, s, t;
    bit hit, got;
    off = addr - BASE;
    s = (off / 8) % NSETS;
    t = (off / (8 * NSETS)) % 1024;
    hit = in_set(s, t);
    e.wr = is_wr;
    e.addr = addr;
    e.hit = hit;
    if (is_wr) begin
      ref_mem[{addr[31:2], 2'b00}] = data;
      e.data = data;
      e.fill = !hit && (ln == 1);
      if (hit || ln == 1) touch(s, t);
    end else begin
      e.data = ref_word(addr);
      e.fill = !hit;
      if (hit) mhit++;
      else mmiss++;
      touch(s, t);
    end
    sb.push_back(e);
    @(posedge clk); #1;
    address = addr;
    wdata = data;
    flush = fl;
    if (is_wr) wr[ln] = 1'b1;
    else rd[ln] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = ready[ln];
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: lane %0d addr %h got no ready, expected ready within 200 cycles", ln, addr);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "request timeout");
    end
    @(posedge clk); #1;
    rd[ln] = 1'b0;
    wr[ln] = 1'b0;
    flush = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    rd[0] = 1'b0; rd[1] = 1'b0; wr[0] = 1'b0; wr[1] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    mhit = 0;
    mmiss = 0;
  endtask

  task automatic do_flush();
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    model_clear();
  endtask

  task automatic check_cnt(input int ln);
    @(negedge clk);
    chk("hit_cnt", 32'(hcnt[ln]), 32'(sat(mhit, ln)));
    chk("miss_cnt", 32'(mcnt[ln]), 32'(sat(mmiss, ln)));
  endtask

  task automatic check_reset(input int ln);
    @(negedge clk);
    chk("reset_ready", 32'(ready[ln]), 32'd1);
    chk("reset_rdata", rdata[ln], 32'd0);
    chk("reset_read_en", 32'(s_re[ln]), 32'd0);
    chk("reset_write_en", 32'(s_we[ln]), 32'd0);
    chk("reset_hit_cnt", 32'(hcnt[ln]), 32'd0);
    chk("reset_miss_cnt", 32'(mcnt[ln]), 32'd0);
  endtask

  task automatic reset_in_fill(input int ln);
    force_dly = 20;
    @(posedge clk); #1;
    address = BASE + 32'd40;
    rd[ln] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("fill_read_en", 32'(s_re[ln]), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    rd[ln] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    mhit = 0;
    mmiss = 0;
    @(negedge clk);
    chk("rst_in_fill_read_en", 32'(s_re[ln]), 32'd0);
    chk("rst_in_fill_ready", 32'(ready[ln]), 32'd1);
    force_dly = -1;
  endtask

  task automatic random_ops(input int ln, input int n);
    int unsigned op;
    logic [31:0] a;
    bit fl;
    for (int i = 0; i < n; i++) begin
      op = $urandom_range(0, 7);
      a = BASE + 32'($urandom_range(0, 3)) * 32'd512 + 32'($urandom_range(0, 3)) * 32'd8
          + 32'($urandom_range(0, 1)) * 32'd4;
      fl = ($urandom_range(0, 7) == 0);
      if (op == 0) do_flush();
      else if (op <= 2) do_req(ln, 1'b1, a, $urandom, fl);
      else do_req(ln, 1'b0, a, 32'd0, fl);
      if (i % 16 == 15) check_cnt(ln);
    end
  endtask

  initial begin
    rd[0] = 1'b0; rd[1] = 1'b0; wr[0] = 1'b0; wr[1] = 1'b0;
    for (int ln = 0; ln < 2; ln++) begin
      ref_mem.delete();
      do_reset();
      check_reset(ln);
      if (ln == 0) begin
        force_dly = 3;
        do_req(0, 1'b0, 32'h400, 32'd0, 1'b0);
        force_dly = -1;
        do_req(0, 1'b0, 32'h404, 32'd0, 1'b0);
        check_cnt(0);
        do_req(0, 1'b0, 32'h600, 32'd0, 1'b0);
        do_req(0, 1'b0, 32'h400, 32'd0, 1'b0);
        do_req(0, 1'b0, 32'h800, 32'd0, 1'b0);
        do_req(0, 1'b0, 32'h400, 32'd0, 1'b0);
        do_req(0, 1'b0, 32'h600, 32'd0, 1'b0);
        do_req(0, 1'b1, 32'h404, 32'hAB, 1'b0);
        do_req(0, 1'b0, 32'h404, 32'd0, 1'b0);
        do_req(0, 1'b1, 32'h438, 32'h1234, 1'b0);
        do_req(0, 1'b0, 32'h438, 32'd0, 1'b0);
        do_flush();
        do_req(0, 1'b0, 32'h400, 32'd0, 1'b0);
        do_req(0, 1'b0, 32'h408, 32'd0, 1'b1);
        do_req(0, 1'b0, 32'h408, 32'd0, 1'b0);
        do_req(0, 1'b0, 32'h400, 32'd0, 1'b1);
        check_cnt(0);
        reset_in_fill(0);
        do_req(0, 1'b0, 32'h400, 32'd0, 1'b0);
        check_cnt(0);
      end else begin
        do_req(1, 1'b1, 32'h438, 32'hCAFE_0001, 1'b0);
        do_req(1, 1'b0, 32'h438, 32'd0, 1'b0);
        do_req(1, 1'b0, 32'h43C, 32'd0, 1'b0);
        do_req(1, 1'b1, 32'h43C, 32'h5555_AAAA, 1'b0);
        do_req(1, 1'b0, 32'h43C, 32'd0, 1'b0);
        check_cnt(1);
      end
      random_ops(ln, 160);
      check_cnt(ln);
    end
    @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    finish_now();
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running at 2 ms, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "global timeout");
  end

endmodule
